// File: rtl/corelet_ctrl.sv
// corelet_ctrl: weight-stationary pass sequencer. Turns a host start/done handshake into the
// corelet's 35-bit inst word, including the xmem/pmem SRAM controls packed inside it.
module corelet_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int len_kij = 9,
  parameter int len_nij = 36,
  parameter int w_base  = 128,
  parameter int k_flush = 8,
  parameter int aw      = 11
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mode_os,
  input  logic        l0_full,
  input  logic        ofifo_valid,
  output logic [34:0] inst,
  output logic        busy,
  output logic        done
);

  if ((row < 1) || (col > 255) || (len_nij > 255) || (len_kij > 255) ||
      (len_kij * len_nij > (2 ** aw))) begin : g_param_check
    $error("corelet_ctrl: parameter set out of range");
  end

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_W_LOAD  = 3'd1,
    S_K_LOAD  = 3'd2,
    S_K_FLUSH = 3'd3,
    S_A_LOAD  = 3'd4,
    S_EXEC    = 3'd5,
    S_DRAIN   = 3'd6
  } state_t;

  // CEN/WEN of both SRAMs high, every strobe low
  localparam logic [33:0] idle_word = 34'h1_800C_0000;
  localparam logic [7:0]  col_c     = 8'(col);
  localparam logic [7:0]  nij_c     = 8'(len_nij);
  localparam logic [7:0]  kij_c     = 8'(len_kij);
  localparam logic [7:0]  flush_c   = 8'(k_flush);

  state_t        state_r, state_s;
  logic [7:0]    cnt_r, cnt_s;
  logic [7:0]    kij_r, kij_s;
  logic          rd_r, rd_s;
  logic [33:0]   inst_r, inst_s;
  logic          mode_r;
  logic          busy_r, busy_s;
  logic          done_r, done_s;
  logic [aw-1:0] xaddr_s, paddr_s;
  logic [7:0]    load_len_s;

  // Address generation for the xmem fetch (weights or activations) and the pmem drain
  always_comb begin
    if (state_r == S_W_LOAD) begin
      xaddr_s    = aw'(w_base + int'(kij_r) * col + int'(cnt_r));
      load_len_s = col_c;
    end else begin
      xaddr_s    = aw'(cnt_r);
      load_len_s = nij_c;
    end
    paddr_s = aw'(int'(kij_r) * len_nij + int'(cnt_r));
  end

  // Next-state and next-inst decode
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    kij_s   = kij_r;
    rd_s    = 1'b0;
    done_s  = 1'b0;
    inst_s  = idle_word;
    // SRAM read data lands one cycle after the read, so l0_wr trails every issued read
    inst_s[2] = rd_r;
    case (state_r)
      S_IDLE: begin
        // done_r blocks a start that arrives in the completion cycle
        if (start && !done_r) begin
          state_s = S_W_LOAD;
          kij_s   = 8'd0;
          cnt_s   = 8'd0;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_W_LOAD, S_A_LOAD: begin
        if (cnt_r == load_len_s) begin
          state_s = (state_r == S_W_LOAD) ? S_K_LOAD : S_EXEC;
          cnt_s   = 8'd0;
        end else if (!l0_full) begin
          rd_s         = 1'b1;
          inst_s[19]   = 1'b0;
          inst_s[17:7] = 11'(xaddr_s);
          cnt_s        = cnt_r + 8'd1;
        end else begin
          cnt_s = cnt_r;
        end
      end
      S_K_LOAD: begin
        inst_s[0] = 1'b1;
        inst_s[3] = 1'b1;
        if (cnt_r == col_c - 8'd1) begin
          state_s = S_K_FLUSH;
          cnt_s   = 8'd0;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      S_K_FLUSH: begin
        if (cnt_r == flush_c - 8'd1) begin
          state_s = S_A_LOAD;
          cnt_s   = 8'd0;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      S_EXEC: begin
        inst_s[1] = 1'b1;
        inst_s[3] = 1'b1;
        if (cnt_r == nij_c - 8'd1) begin
          state_s = S_DRAIN;
          cnt_s   = 8'd0;
        end else begin
          cnt_s = cnt_r + 8'd1;
        end
      end
      S_DRAIN: begin
        if (ofifo_valid) begin
          inst_s[6]     = 1'b1;
          inst_s[32]    = 1'b0;
          inst_s[31]    = 1'b0;
          inst_s[30:20] = 11'(paddr_s);
          if (cnt_r == nij_c - 8'd1) begin
            cnt_s = 8'd0;
            if (kij_r < kij_c - 8'd1) begin
              state_s = S_W_LOAD;
              kij_s   = kij_r + 8'd1;
            end else begin
              state_s = S_IDLE;
              done_s  = 1'b1;
            end
          end else begin
            cnt_s = cnt_r + 8'd1;
          end
        end else begin
          cnt_s = cnt_r;
        end
      end
      default: begin
        state_s = S_IDLE;
        cnt_s   = 8'd0;
      end
    endcase
    busy_s = (state_s != S_IDLE);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      cnt_r   <= 8'd0;
      kij_r   <= 8'd0;
      rd_r    <= 1'b0;
      inst_r  <= idle_word;
      mode_r  <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      kij_r   <= kij_s;
      rd_r    <= rd_s;
      inst_r  <= inst_s;
      mode_r  <= mode_os;
      busy_r  <= busy_s;
      done_r  <= done_s;
    end
  end

  assign inst = {mode_r, inst_r};
  assign busy = busy_r;
  assign done = done_r;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Scoreboard bench for corelet_ctrl: expected SRAM address streams are queued per pass from the
// pass definition, and a negedge monitor pops and compares whenever the DUT drives an SRAM access.
module tb_corelet_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        mode_os = 1'b0;
  logic        l0_full = 1'b0;
  logic        ofifo_valid = 1'b0;
  logic [34:0] inst;
  logic        busy;
  logic        done;

  corelet_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .mode_os(mode_os), .l0_full(l0_full),
    .ofifo_valid(ofifo_valid), .inst(inst), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int          n_cmp = 0;
  int          n_err = 0;
  int unsigned exp_x[$];
  int unsigned exp_p[$];
  int unsigned ea, ep;
  int          done_seen = 0;
  int          l0_wr_cnt = 0;
  int          pat = 0;
  int          bp_left = 0;
  logic        bp_arm = 1'b0;
  int          cyc = 0;
  logic        lf_edge = 1'b0, ofv_edge = 1'b0, prev_rd = 1'b0;
  logic        rd_now, wr_now;
  logic [34:0] idle_w;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the address streams one whole pass must produce, in order
  task automatic push_pass();
    for (int k = 0; k < 9; k++) begin
      for (int c = 0; c < 8; c++) exp_x.push_back((128 + k * 8 + c) % 2048);
      for (int n = 0; n < 36; n++) exp_x.push_back(n % 2048);
      for (int m = 0; m < 36; m++) exp_p.push_back((k * 36 + m) % 2048);
    end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1;
    start = 1'b1;
    l0_wr_cnt = 0;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
  endtask

  task automatic wait_done(input bit start_in_done);
    bit found = 0;
    for (int i = 0; i < 20000; i++) begin
      @(posedge clk); #1;
      if (done) begin
        found = 1;
        break;
      end
    end
    chk("done_timeout", found, 1);
    if (start_in_done) begin
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
    end
    repeat (30) @(posedge clk);
    #1;
    chk("busy_idle_after_done", busy, 0);
  endtask

  // Input samples as seen by the DUT at each rising edge
  always @(posedge clk) begin
    lf_edge  <= l0_full;
    ofv_edge <= ofifo_valid;
  end

  // Back-pressure / OFIFO stimulus driver
  always @(posedge clk) begin
    #1;
    cyc++;
    case (pat)
      0: begin
        l0_full     = 1'b0;
        ofifo_valid = 1'b1;
      end
      1: begin
        if (bp_left > 0) begin
          l0_full = 1'b1;
          bp_left--;
        end else begin
          l0_full = 1'b0;
        end
        ofifo_valid = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      end
      default: begin
        l0_full     = ($urandom_range(0, 3) == 0);
        ofifo_valid = ($urandom_range(0, 2) != 0);
      end
    endcase
  end

  // Monitor: protocol checks and scoreboard pops on every SRAM access
  always @(negedge clk) begin
    if (!reset) begin
      prev_rd = 1'b0;
    end else begin
      rd_now = !inst[19];
      wr_now = !inst[32];
      chk("l0_wr_follows_read", inst[2], prev_rd);
      if (inst[2]) l0_wr_cnt++;
      chk("l0_wr_and_l0_rd", inst[2] & inst[3], 0);
      chk("xmem_pmem_cen_both_low", rd_now & wr_now, 0);
      chk("ififo_acc_bits", {inst[33], inst[5:4]}, 0);
      chk("ofifo_rd_eq_pmem_wr", inst[6], wr_now);
      if (rd_now || (wr_now && !done)) chk("busy_during_pass", busy, 1);
      if (rd_now) begin
        chk("xmem_read_while_full", lf_edge, 0);
        chk("xmem_wen", inst[18], 1);
        chk("xmem_read_expected", exp_x.size() > 0, 1);
        if (exp_x.size() > 0) begin
          ea = exp_x.pop_front();
          chk("xmem_addr", inst[17:7], ea);
          if (bp_arm && ea == 9) begin
            bp_left = 5;
            bp_arm  = 1'b0;
          end
        end
      end
      if (wr_now) begin
        chk("pmem_wen", inst[31], 0);
        chk("pmem_write_needs_valid", ofv_edge, 1);
        chk("pmem_write_expected", exp_p.size() > 0, 1);
        if (exp_p.size() > 0) begin
          ep = exp_p.pop_front();
          chk("pmem_addr", inst[30:20], ep);
        end
      end
      if (done) begin
        done_seen++;
        chk("busy_low_at_done", busy, 0);
        chk("pmem_all_written_at_done", exp_p.size(), 0);
        chk("xmem_all_read_at_done", exp_x.size(), 0);
        chk("l0_wr_total", l0_wr_cnt, 9 * 44);
      end
      prev_rd = rd_now;
    end
  end

  initial begin
    idle_w = '0;
    idle_w[18] = 1'b1;
    idle_w[19] = 1'b1;
    idle_w[31] = 1'b1;
    idle_w[32] = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    chk("reset_inst", inst, idle_w);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    reset = 1'b1;
    @(posedge clk); #1;
    chk("idle_after_release", inst, idle_w);

    // Pass 1: no stalls; start pulsed mid-pass and in the done cycle must be ignored
    pat = 0;
    push_pass();
    pulse_start();
    repeat (100) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done(1);
    chk("done_count_pass1", done_seen, 1);

    // Pass 2: L0 burst back-pressure at n=10, OFIFO 1,0,0,1 pattern; must restart at kij=0
    pat = 1;
    bp_arm = 1'b1;
    push_pass();
    pulse_start();
    wait_done(0);
    chk("done_count_pass2", done_seen, 2);
    chk("bp_burst_fired", bp_arm, 0);

    // Pass 3: random back-pressure and OFIFO availability
    pat = 2;
    push_pass();
    pulse_start();
    wait_done(0);
    chk("done_count_pass3", done_seen, 3);

    // Reset in the middle of EXEC aborts the pass without a done pulse
    push_pass();
    pulse_start();
    begin
      bit seen_exec = 0;
      for (int i = 0; i < 5000; i++) begin
        @(negedge clk);
        if (inst[1]) begin
          seen_exec = 1;
          break;
        end
      end
      chk("exec_reached", seen_exec, 1);
    end
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("midexec_reset_inst", inst, idle_w);
    chk("midexec_reset_busy", busy, 0);
    chk("midexec_reset_done", done, 0);
    exp_x.delete();
    exp_p.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    chk("idle_after_abort", busy, 0);
    chk("no_done_on_abort", done_seen, 3);

    // Pass 4: full recovery after the abort
    pat = 2;
    push_pass();
    pulse_start();
    wait_done(0);
    chk("done_count_pass4", done_seen, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
